// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM encoding,
// default parameter values and the counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_NUM_OUT     = 4;
  localparam int DEF_STRETCH_CYC = 8;
  localparam int DEF_STAGE_GAP   = 4;

  // Bits needed to count 0..max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchronizer for an asynchronous request level; both stages
// clear asynchronously to 0 while rst is high.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture to settle metastability before the FSM samples it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d_async;
      sync_r <= meta_r;
    end
  end

  assign q_sync = sync_r;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all reset outputs high for a stretch after the last
// request, then releases them one by one (bit 0 first) and pulses done.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int STRETCH_CYC = DEF_STRETCH_CYC,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic               ext_rst_req_async,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(STRETCH_CYC, STAGE_GAP);
  localparam int SW = cnt_width(NUM_OUT, 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYC - 32'd1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 32'd1);
  localparam logic [SW-1:0] STAGE_LAST   = SW'(NUM_OUT - 32'd1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);
  localparam logic [SW-1:0] STAGE_ONE    = SW'(1'b1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_nxt_s;
  logic [SW-1:0]      stage_r;
  logic [SW-1:0]      stage_nxt_s;
  logic [NUM_OUT-1:0] rst_out_r;
  logic [NUM_OUT-1:0] rst_out_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic               ext_sync_s;
  logic               req_s;

  rst_sync_2ff u_ext_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (ext_rst_req_async),
    .q_sync  (ext_sync_s)
  );

  assign req_s = sw_rst_req | ext_sync_s;

  // Next-state logic; a request in any state restarts the stretch
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    stage_nxt_s   = stage_r;
    rst_out_nxt_s = rst_out_r;
    if (req_s) begin
      state_nxt_s   = ST_ASSERT;
      cnt_nxt_s     = {CW{1'b0}};
      stage_nxt_s   = {SW{1'b0}};
      rst_out_nxt_s = {NUM_OUT{1'b1}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          rst_out_nxt_s = {NUM_OUT{1'b0}};
        end
        ST_ASSERT: begin
          if (cnt_r == STRETCH_LAST) begin
            state_nxt_s = ST_RELEASE;
            cnt_nxt_s   = {CW{1'b0}};
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == GAP_LAST) begin
            rst_out_nxt_s[stage_r] = 1'b0;
            cnt_nxt_s              = {CW{1'b0}};
            // Stage wraps to 0 on the last release so it never overflows
            if (stage_r == STAGE_LAST) begin
              state_nxt_s = ST_DONE;
              stage_nxt_s = {SW{1'b0}};
            end else begin
              stage_nxt_s = stage_r + STAGE_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_nxt_s   = ST_IDLE;
          rst_out_nxt_s = {NUM_OUT{1'b0}};
        end
        default: begin
          state_nxt_s   = ST_ASSERT;
          cnt_nxt_s     = {CW{1'b0}};
          stage_nxt_s   = {SW{1'b0}};
          rst_out_nxt_s = {NUM_OUT{1'b1}};
        end
      endcase
    end
  end

  // State and output registers; busy/done are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_ASSERT;
      cnt_r     <= {CW{1'b0}};
      stage_r   <= {SW{1'b0}};
      rst_out_r <= {NUM_OUT{1'b1}};
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      stage_r   <= stage_nxt_s;
      rst_out_r <= rst_out_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  assign rst_out = rst_out_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected output changes
// (edge number and values); a monitor pops and compares on every change.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic       ext_rst_req_async;
  logic [3:0] rst_out;
  logic       busy;
  logic       done;

  typedef struct {
    int         ed;
    logic [3:0] ro;
    logic       bsy;
    logic       dn;
  } ev_t;

  ev_t exp_q[$];
  int  edge_cnt = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  rst_seq_ctrl #(
    .NUM_OUT     (4),
    .STRETCH_CYC (8),
    .STAGE_GAP   (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sw_rst_req        (sw_rst_req),
    .ext_rst_req_async (ext_rst_req_async),
    .rst_out           (rst_out),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge numbering: first edge after reset release is edge 1
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic push_ev(input int ed, input logic [3:0] ro, input logic bsy, input logic dn);
    ev_t ev;
    ev.ed = ed; ev.ro = ro; ev.bsy = bsy; ev.dn = dn;
    exp_q.push_back(ev);
  endtask

  // Release schedule relative to the last edge k that sampled a request
  task automatic push_seq(input int k);
    push_ev(k + 12, 4'hE, 1'b1, 1'b0);
    push_ev(k + 16, 4'hC, 1'b1, 1'b0);
    push_ev(k + 20, 4'h8, 1'b1, 1'b0);
    push_ev(k + 24, 4'h0, 1'b1, 1'b1);
    push_ev(k + 25, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic drop_from(input int ed);
    ev_t keep[$];
    foreach (exp_q[i]) if (exp_q[i].ed < ed) keep.push_back(exp_q[i]);
    exp_q = keep;
  endtask

  task automatic check_out(input string name, input logic [3:0] ro, input logic bsy, input logic dn);
    n_checks++;
    if (rst_out === ro && busy === bsy && done === dn) n_pass++;
    else $display("FAIL %s: rst_out=%h busy=%b done=%b, required rst_out=%h busy=%b done=%b",
                  name, rst_out, busy, done, ro, bsy, dn);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d expected events pending at edge %0d, required 0 (next at edge %0d)",
               name, exp_q.size(), edge_cnt, exp_q[0].ed);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: any change on the outputs must match the head of the queue
  initial begin : monitor
    logic [5:0] cur;
    logic [5:0] prev;
    ev_t        ev;
    prev = 6'b111110;
    forever begin
      @(negedge clk);
      cur = {rst_out, busy, done};
      if (rst) begin
        prev = cur;
      end else if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: edge=%0d rst_out=%h busy=%b done=%b, required no change",
                   edge_cnt, rst_out, busy, done);
        end else begin
          ev = exp_q.pop_front();
          if (ev.ed == edge_cnt && ev.ro === rst_out && ev.bsy === busy && ev.dn === done)
            n_pass++;
          else
            $display("FAIL event: edge=%0d rst_out=%h busy=%b done=%b, required edge=%0d rst_out=%h busy=%b done=%b",
                     edge_cnt, rst_out, busy, done, ev.ed, ev.ro, ev.bsy, ev.dn);
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    int k;
    int k2;
    rst = 1'b1;
    sw_rst_req = 1'b0;
    ext_rst_req_async = 1'b0;

    // Power-on: values held before any clock edge, then the default sequence
    #1 check_out("reset_no_clock", 4'hF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_out("reset_clocked", 4'hF, 1'b1, 1'b0);
    push_seq(0);
    rst = 1'b0;
    wait_drain(40, "power_on");
    check_out("idle_after_power_on", 4'h0, 1'b0, 1'b0);

    // Single-cycle software request in IDLE
    @(negedge clk);
    k = edge_cnt + 1;
    sw_rst_req = 1'b1;
    push_ev(k, 4'hF, 1'b1, 1'b0);
    push_seq(k);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain(40, "sw_pulse");

    // Held request: sampled high on 20 edges, releases timed from the last
    @(negedge clk);
    k = edge_cnt + 1;
    sw_rst_req = 1'b1;
    push_ev(k, 4'hF, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    k2 = edge_cnt;
    sw_rst_req = 1'b0;
    push_seq(k2);
    wait_drain(40, "sw_held");

    // Abort after bit1 has released
    @(negedge clk);
    k = edge_cnt + 1;
    sw_rst_req = 1'b1;
    push_ev(k, 4'hF, 1'b1, 1'b0);
    push_seq(k);
    @(negedge clk);
    sw_rst_req = 1'b0;
    while (edge_cnt < k + 17) @(negedge clk);
    k2 = edge_cnt + 1;
    sw_rst_req = 1'b1;
    drop_from(k2);
    push_ev(k2, 4'hF, 1'b1, 1'b0);
    push_seq(k2);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain(50, "sw_abort");

    // External request changing between edges: 2 sync edges + sampling edge
    @(posedge clk);
    #2;
    k = edge_cnt + 1;
    ext_rst_req_async = 1'b1;
    push_ev(k + 2, 4'hF, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    k2 = edge_cnt;
    ext_rst_req_async = 1'b0;
    push_seq(k2 + 2);
    wait_drain(50, "ext_req");

    // Asynchronous reset mid-RELEASE, then the power-on sequence again
    @(negedge clk);
    k = edge_cnt + 1;
    sw_rst_req = 1'b1;
    push_ev(k, 4'hF, 1'b1, 1'b0);
    push_seq(k);
    @(negedge clk);
    sw_rst_req = 1'b0;
    while (edge_cnt < k + 14) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1 check_out("async_reset_no_clock", 4'hF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_out("async_reset_clocked", 4'hF, 1'b1, 1'b0);
    push_seq(0);
    rst = 1'b0;
    wait_drain(40, "reset_repeat");
    check_out("idle_final", 4'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that drives the other side of the reset path: it asserts a set of reset outputs, stretches them, then releases them one at a time in a fixed order.
- Outputs are registered and active-high; they feed per-subsystem resets in a single clock domain.
- Reset requests come from a synchronous software request and an asynchronous external request. The external request is synchronized internally.
- Reports busy and emits a done pulse when the full release sequence completes.

Parameters:
- NUM_OUT, 4, number of reset outputs, >=1; released in order bit 0 first.
- STRETCH_CYC, 8, cycles all outputs stay asserted after the last sampled request, >=1.
- STAGE_GAP, 4, cycles between successive output releases, >=1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- sw_rst_req  input  1  synchronous reset request (level); sampled every edge
- ext_rst_req_async  input  1  asynchronous active-high reset request; synchronized internally
- rst_out  output  NUM_OUT  active-high reset outputs, registered
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - rst_out = all ones, busy=1, done=0.
  - State = ASSERT, stretch counter = 0, stage index = 0, synchronizer flops = 0.
  - No clock is required for outputs to take these values.
- Effective request: req = sw_rst_req OR ext_sync, where ext_sync is the 2-flop synchronized ext_rst_req_async.
- States: IDLE, ASSERT, RELEASE, DONE. In every state, req=1 at an edge forces ASSERT, cnt=0, stage=0 and rst_out=all ones at that same edge.
- ASSERT:
  - cnt increments by 1 per edge.
  - At the edge where cnt==STRETCH_CYC-1, move to RELEASE with cnt=0.
- RELEASE:
  - cnt increments by 1 per edge.
  - At the edge where cnt==STAGE_GAP-1: clear rst_out[stage], stage++, cnt=0.
  - When the cleared stage is NUM_OUT-1, move to DONE at that same edge.
- DONE: lasts one cycle with done=1, then moves to IDLE.
- IDLE: rst_out=0, busy=0; waits for req.
- Timing relative to edge k, the last edge at which req was sampled high (the first post-reset edge counts as edge 1, and reset release behaves like k=0):
  - rst_out[i] falls at edge k+STRETCH_CYC+STAGE_GAP*(i+1).
  - done is high for the cycle after edge k+STRETCH_CYC+STAGE_GAP*NUM_OUT.
  - busy falls one edge later.
- Held request: while req stays high, the sequencer stays in ASSERT with cnt=0, so the stretch restarts from the last high sample.
- Request during RELEASE or DONE: abort; all outputs are re-asserted at the next edge and no done pulse is emitted.
- External request latency: 2 edges of synchronization plus the sampling edge.
- Counter widths:
  - cnt width = clog2(max(STRETCH_CYC, STAGE_GAP)), minimum 1.
  - stage width = clog2(NUM_OUT), minimum 1.
  - No wrap-around: the counters reset before they reach their terminal count + 1.
- Outputs are glitch-free: every output comes directly from a flop.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum (IDLE, ASSERT, RELEASE, DONE);
  - default parameter constants;
  - a width helper function.
- Sub-module rst_sync_2ff: a 2-flop synchronizer for ext_rst_req_async, asynchronously cleared to 0 by rst.

Test Plan:
- Power-on (defaults): rst=1, then released.
  - rst_out=4'hF during reset.
  - bit0 falls at edge 12, bit1 at 16, bit2 at 20, bit3 at 24.
  - done=1 for the cycle after edge 24; busy=0 after edge 25.
- sw_rst_req one-cycle pulse in IDLE, sampled at edge k:
  - rst_out=4'hF after edge k.
  - releases at k+12, k+16, k+20, k+24; a single done pulse.
- sw_rst_req held for 20 cycles: release times are measured from the last high sample, and no release occurs while req is held.
- sw_rst_req pulse after bit1 has released (mid-RELEASE):
  - rst_out returns to 4'hF at the next edge.
  - no done pulse from the aborted sequence.
  - the full sequence restarts with the timing above.
- ext_rst_req_async asserted between edges while in IDLE:
  - rst_out=4'hF within 3 edges.
  - the release sequence starts after the request drops.
- rst asserted asynchronously mid-RELEASE:
  - rst_out=4'hF, busy=1, done=0 immediately, without a clock edge.
  - after rst is released, the power-on sequence repeats.
